// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V control sequencer with memory handshake and timeout
// Moore sequencer; only ir_en and pc_en/retire in the memory wait states look at mem_ready.
module multicycle_controller #(
   parameter int unsigned TIMEOUT     = 16,
   parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       IorD,
   output logic       ir_en,
   output logic       pc_en,
   output logic       ALUSrc,
   output logic [1:0] ALUOp,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       Branch,
   output logic       retire,
   output logic       halt,
   output logic       fault,
   output logic [2:0] state_o
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JR = 7'b1100111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   state_t         state, state_next;
   logic [6:0]     op_q, op_next;
   logic [CW-1:0]  cnt, cnt_next;

   logic       req_c, we_c, iord_c, ir_c, pc_c, src_c, m2r_c, rw_c, br_c, halt_c, fault_c;
   logic [1:0] aluop_c;
   logic       is_lw, is_sw, is_br, is_i, is_r, is_jump, legal;

   assign is_lw   = (op_q == OP_LW);
   assign is_sw   = (op_q == OP_SW);
   assign is_br   = (op_q == OP_BR);
   assign is_i    = (op_q == OP_I);
   assign is_r    = (op_q == OP_R);
   assign is_jump = (op_q == OP_J) || (op_q == OP_JR);
   assign legal   = (Opcode == OP_R)  || (Opcode == OP_LW) || (Opcode == OP_SW) ||
                    (Opcode == OP_BR) || (Opcode == OP_I)  || (Opcode == OP_J)  ||
                    (Opcode == OP_JR);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_FETCH;
         op_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         op_q  <= op_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      op_next    = op_q;
      cnt_next   = '0;
      req_c      = 1'b0;
      we_c       = 1'b0;
      iord_c     = 1'b0;
      ir_c       = 1'b0;
      pc_c       = 1'b0;
      src_c      = 1'b0;
      aluop_c    = 2'b00;
      m2r_c      = 1'b0;
      rw_c       = 1'b0;
      br_c       = 1'b0;
      halt_c     = 1'b0;
      fault_c    = 1'b0;
      case (state)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               ir_c       = 1'b1;
               state_next = S_DECODE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_next = S_FAULT;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         S_DECODE: begin
            op_next = Opcode;
            if (legal)                       state_next = S_EXEC;
            else if (Opcode == HALT_OPCODE)  state_next = S_HALTED;
            else                             state_next = S_FAULT;
         end
         S_EXEC: begin
            src_c = is_lw || is_sw || is_i;
            if (is_br)                aluop_c = 2'b01;
            else if (is_r || is_i)    aluop_c = 2'b10;
            else if (is_jump)         aluop_c = 2'b11;
            if (is_r || is_i) begin
               state_next = S_WB;
            end else if (is_lw || is_sw) begin
               state_next = S_MEM;
            end else begin
               // Branches and jumps resolve here; jumps also write the link register.
               br_c       = 1'b1;
               rw_c       = is_jump;
               pc_c       = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_MEM: begin
            req_c  = 1'b1;
            iord_c = 1'b1;
            src_c  = 1'b1;
            we_c   = is_sw;
            if (mem_ready) begin
               pc_c       = is_sw;
               state_next = is_sw ? S_FETCH : S_WB;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_next = S_FAULT;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         S_WB: begin
            rw_c       = 1'b1;
            m2r_c      = is_lw;
            pc_c       = 1'b1;
            state_next = S_FETCH;
         end
         S_HALTED: halt_c  = 1'b1;
         S_FAULT:  fault_c = 1'b1;
         default:  state_next = S_FETCH;
      endcase
   end

   // Outputs are forced quiet combinationally while reset is held low.
   assign mem_req  = reset & req_c;
   assign mem_we   = reset & we_c;
   assign IorD     = reset & iord_c;
   assign ir_en    = reset & ir_c;
   assign pc_en    = reset & pc_c;
   assign retire   = reset & pc_c;
   assign ALUSrc   = reset & src_c;
   assign ALUOp    = reset ? aluop_c : 2'b00;
   assign MemtoReg = reset & m2r_c;
   assign RegWrite = reset & rw_c;
   assign Branch   = reset & br_c;
   assign halt     = reset & halt_c;
   assign fault    = reset & fault_c;
   assign state_o  = reset ? state : 3'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
// Expected per-cycle outputs come from an instruction-level table of the controller's cycle rules.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] Opcode = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, IorD, ir_en, pc_en, ALUSrc, MemtoReg, RegWrite, Branch;
   logic       retire, halt, fault;
   logic [1:0] ALUOp;
   logic [2:0] state_o;

   multicycle_controller #(.TIMEOUT(16), .HALT_OPCODE(7'b1111111)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .ir_en(ir_en), .pc_en(pc_en),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .Branch(Branch), .retire(retire), .halt(halt), .fault(fault), .state_o(state_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JR = 7'b1100111;

   localparam logic [16:0] REQ   = 17'd1 << 13;
   localparam logic [16:0] WE    = 17'd1 << 12;
   localparam logic [16:0] IORD  = 17'd1 << 11;
   localparam logic [16:0] IR    = 17'd1 << 10;
   localparam logic [16:0] RET   = (17'd1 << 9) | (17'd1 << 2);
   localparam logic [16:0] ASRC  = 17'd1 << 8;
   localparam logic [16:0] A01   = 17'd1 << 6;
   localparam logic [16:0] A10   = 17'd2 << 6;
   localparam logic [16:0] A11   = 17'd3 << 6;
   localparam logic [16:0] M2R   = 17'd1 << 5;
   localparam logic [16:0] RW    = 17'd1 << 4;
   localparam logic [16:0] BR    = 17'd1 << 3;
   localparam logic [16:0] HALTB = 17'd1 << 1;
   localparam logic [16:0] FLT   = 17'd1;

   typedef struct packed {
      logic [6:0]  opc;
      logic        rdy;
      logic [16:0] exp;
   } rec_t;

   rec_t        q[$];
   rec_t        r;
   logic [16:0] got;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [16:0] st(input int s);
      return {3'(s), 14'd0};
   endfunction

   function automatic logic [6:0] rnd7();
      return 7'($urandom);
   endfunction

   function automatic logic rnd1();
      return 1'($urandom);
   endfunction

   function automatic logic [6:0] pick_op();
      case ($urandom_range(0, 6))
         0: return OP_R;
         1: return OP_LW;
         2: return OP_SW;
         3: return OP_BR;
         4: return OP_I;
         5: return OP_J;
         default: return OP_JR;
      endcase
   endfunction

   task automatic push(input logic [6:0] opc, input logic rdy, input logic [16:0] exp);
      q.push_back('{opc: opc, rdy: rdy, exp: exp});
   endtask

   task automatic gen_fetch(input int fw);
      for (int i = 0; i < fw; i++) push(rnd7(), 1'b0, st(0) | REQ);
      push(rnd7(), 1'b1, st(0) | REQ | IR);
   endtask

   task automatic gen_mem(input int mw, input logic [16:0] base, input logic [16:0] done);
      for (int i = 0; i < mw; i++) push(rnd7(), 1'b0, st(3) | base);
      push(rnd7(), 1'b1, st(3) | base | done);
   endtask

   // One complete instruction: fetch with fw wait cycles, decode, then class-specific cycles.
   task automatic gen_instr(input logic [6:0] opc, input int fw, input int mw);
      gen_fetch(fw);
      push(opc, rnd1(), st(1));
      case (opc)
         OP_R:  begin push(rnd7(), rnd1(), st(2) | A10);        push(rnd7(), rnd1(), st(4) | RW | RET); end
         OP_I:  begin push(rnd7(), rnd1(), st(2) | ASRC | A10); push(rnd7(), rnd1(), st(4) | RW | RET); end
         OP_BR: push(rnd7(), rnd1(), st(2) | A01 | BR | RET);
         OP_J, OP_JR: push(rnd7(), rnd1(), st(2) | A11 | BR | RW | RET);
         OP_LW: begin
            push(rnd7(), rnd1(), st(2) | ASRC);
            gen_mem(mw, REQ | IORD | ASRC, 17'd0);
            push(rnd7(), rnd1(), st(4) | RW | M2R | RET);
         end
         default: begin
            push(rnd7(), rnd1(), st(2) | ASRC);
            gen_mem(mw, REQ | IORD | ASRC | WE, RET);
         end
      endcase
   endtask

   task automatic step(input rec_t rr, output logic [16:0] obs);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      Opcode    = rr.opc;
      mem_ready = rr.rdy;
      @(negedge clk);
      obs = {state_o, mem_req, mem_we, IorD, ir_en, pc_en, ALUSrc, ALUOp,
             MemtoReg, RegWrite, Branch, retire, halt, fault};
   endtask

   task automatic reset_cycle(output logic [16:0] obs);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      Opcode    = rnd7();
      mem_ready = 1'b1;
      @(negedge clk);
      obs = {state_o, mem_req, mem_we, IorD, ir_en, pc_en, ALUSrc, ALUOp,
             MemtoReg, RegWrite, Branch, retire, halt, fault};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         reset_cycle(got);
         n_cmp++;
         if (got !== 17'd0) begin
            n_bad++;
            $display("FAIL test_reset: outputs got %h expected %h", got, 17'd0);
         end
      end
   endtask

   task automatic test_directed();
      gen_instr(OP_R, 0, 0);
      gen_instr(OP_LW, 0, 3);
      gen_instr(OP_SW, 0, 0);
      gen_instr(OP_BR, 0, 0);
      gen_instr(OP_J, 0, 0);
      gen_instr(OP_JR, 1, 0);
      gen_instr(OP_I, 2, 0);
      gen_instr(OP_R, 15, 0);
      gen_instr(OP_SW, 0, 15);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_directed cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         gen_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_random cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 16; i++) push(rnd7(), 1'b0, st(0) | REQ);
      for (int i = 0; i < 20; i++) push(rnd7(), 1'(i % 2 == 0), st(6) | FLT);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_timeout_fetch cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
      reset_cycle(got);
      gen_fetch(0);
      push(OP_SW, rnd1(), st(1));
      push(rnd7(), rnd1(), st(2) | ASRC);
      for (int i = 0; i < 16; i++) push(rnd7(), 1'b0, st(3) | REQ | IORD | ASRC | WE);
      for (int i = 0; i < 6; i++) push(rnd7(), 1'b1, st(6) | FLT);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_timeout_mem cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
      reset_cycle(got);
   endtask

   task automatic test_halt();
      gen_fetch(0);
      push(7'b1111111, rnd1(), st(1));
      for (int i = 0; i < 20; i++) push(rnd7(), rnd1(), st(5) | HALTB);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_halt cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
      reset_cycle(got);
      n_cmp++;
      if (got !== 17'd0) begin
         n_bad++;
         $display("FAIL test_halt_reset: got %h expected %h", got, 17'd0);
      end
      gen_instr(OP_BR, 0, 0);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_halt_recover cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
   endtask

   task automatic test_illegal_and_mid_reset();
      gen_fetch(1);
      push(7'b0000000, rnd1(), st(1));
      for (int i = 0; i < 5; i++) push(rnd7(), rnd1(), st(6) | FLT);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_illegal cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
      reset_cycle(got);
      gen_fetch(0);
      push(OP_LW, rnd1(), st(1));
      push(rnd7(), rnd1(), st(2) | ASRC);
      push(rnd7(), 1'b0, st(3) | REQ | IORD | ASRC);
      push(rnd7(), 1'b0, st(3) | REQ | IORD | ASRC);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_mid_reset_pre cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
      reset_cycle(got);
      n_cmp++;
      if (got !== 17'd0) begin
         n_bad++;
         $display("FAIL test_mid_reset: got %h expected %h", got, 17'd0);
      end
      gen_instr(OP_R, 0, 0);
      for (int k = 0; q.size() > 0; k++) begin
         r = q.pop_front();
         step(r, got);
         n_cmp++;
         if (got !== r.exp) begin
            n_bad++;
            $display("FAIL test_mid_reset_post cycle %0d: got %h expected %h", k, got, r.exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_halt();
      test_illegal_and_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style sequencer that runs the RISC-V datapath in multi-cycle mode: FETCH, DECODE, EXEC, MEM, WB. It reuses the single-cycle opcode classes and ALUOp encoding, and adds the things a shared single-port memory needs: a memory ready handshake with timeout, sticky halt/fault handling and an instruction-retire pulse. It sits beside the datapath and drives the PC/IR enables, memory request and register-file write controls.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for mem_ready before FAULT (must be >=1)
HALT_OPCODE, 7'b1111111, opcode that enters HALTED

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset (reset==0 at posedge resets)
Opcode  in  7  instruction[6:0] from the IR; sampled only in DECODE
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory access request (FETCH, MEM)
mem_we  out  1  write strobe, only in MEM for SW
IorD  out  1  0: address = PC (fetch), 1: address = ALU result (data)
ir_en  out  1  load instruction register
pc_en  out  1  update PC (PC+4 or branch target selected by datapath)
ALUSrc  out  1  0: rs2, 1: immediate
ALUOp  out  2  00 LW/SW, 01 branch, 10 R/I-type, 11 JAL/JALR
MemtoReg  out  1  writeback source is memory
RegWrite  out  1  register file write enable
Branch  out  1  branch/jump resolution cycle
retire  out  1  one-cycle pulse per completed instruction
halt  out  1  sticky, HALTED state
fault  out  1  sticky, FAULT state
state_o  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALTED=5 FAULT=6

Behaviour:
- Reset: state=FETCH, op_q=0, wait counter=0. While reset==0, all outputs are 0 except state_o=0.
- Outputs decode from state and op_q. Exceptions: ir_en and pc_en/retire in wait states also qualify on mem_ready. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, IorD=0.
  - If mem_ready: ir_en=1, go to DECODE.
  - Else the counter increments. When the counter reaches TIMEOUT with no ready, go to FAULT.
  - A request is accepted if ready arrives in any of the first TIMEOUT request cycles. Ready on cycle TIMEOUT wins over timeout.
- DECODE: op_q<=Opcode.
  - Class R=0110011, LW=0000011, SW=0100011, BR=1100011, I=0010011, J=1101111, JR=1100111 -> EXEC.
  - Opcode==HALT_OPCODE -> HALTED.
  - Any other opcode -> FAULT.
  - The counter clears on every entry to FETCH or MEM.
- EXEC:
  - ALUSrc=1 for LW/SW/I.
  - ALUOp: LW/SW 00, BR 01, R/I 10, J/JR 11.
  - R/I -> WB. LW/SW -> MEM.
  - BR: Branch=1, pc_en=1, retire=1 -> FETCH.
  - J/JR: Branch=1, RegWrite=1 (link), pc_en=1, retire=1 -> FETCH.
- MEM:
  - mem_req=1, IorD=1, ALUSrc=1, ALUOp=00, mem_we=(SW).
  - Wait/timeout rule identical to FETCH.
  - On mem_ready: LW -> WB. SW: pc_en=1, retire=1 -> FETCH.
- WB:
  - RegWrite=1, MemtoReg=(LW), pc_en=1, retire=1 -> FETCH.
- HALTED: halt=1, no memory request, no other activity; leave only via reset.
- FAULT: fault=1, no request; leave only via reset. The fault cause is not recorded.
- Latency with zero-wait memory (ready in first request cycle): BR/J/JR 3 cycles, R/I/SW 4, LW 5. Each memory wait cycle adds 1.
- mem_we is never high without mem_req. pc_en and retire are always coincident. ir_en is high only in FETCH.
- Reset asserted mid-request (any state) returns to FETCH next cycle. The pending memory handshake is abandoned, and a late mem_ready is ignored unless in FETCH/MEM.
- mem_ready outside FETCH/MEM is ignored. Opcode changes outside DECODE have no effect.

Test Plan:
- Reset then mem_ready=1 always, IR=0110011: states 0,1,2,4,0. RegWrite=1 only in WB, ALUOp=10 in EXEC, retire pulse on cycle 4.
- LW (0000011) with mem_ready low for 3 MEM cycles: MEM held 4 cycles with mem_req=1, IorD=1, mem_we=0. Then WB with MemtoReg=1, RegWrite=1. 8 cycles total.
- SW, then BEQ (1100011), then JAL (1101111), zero-wait:
  - SW: mem_we=1 for exactly one cycle, no RegWrite.
  - BEQ: 3 cycles, Branch=1, ALUOp=01, RegWrite=0.
  - JAL: 3 cycles, ALUOp=11, RegWrite=1.
- FETCH timeout, TIMEOUT=16:
  - Ready on request cycle 16: accepted, DECODE.
  - Ready never asserted: FAULT after 16 request cycles, fault=1, stays through 10 further ready pulses.
- Opcode 1111111: DECODE -> HALTED, halt=1, mem_req=0 for 20 cycles. reset=0 for one cycle: state_o=0, halt=0.
- Illegal opcode 0000000 -> FAULT. Reset asserted during MEM wait -> FETCH, all outputs 0 during reset cycle.
